// File: rtl/sprite_blitter_if.sv
// Command channel between the game logic (master) and the sprite blitter (slave).
// A draw command transfers on a posedge where cmd_valid && cmd_ready.
interface sprite_blitter_if #(
    parameter int ROM_AW = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [9:0]        cmd_x;
    logic [9:0]        cmd_y;
    logic [ROM_AW-1:0] cmd_base;

    // Command source: offers commands, observes back-pressure.
    modport master (
        output cmd_valid,
        output cmd_x,
        output cmd_y,
        output cmd_base,
        input  cmd_ready
    );

    // Blitter: consumes commands, drives back-pressure.
    modport slave (
        input  cmd_valid,
        input  cmd_x,
        input  cmd_y,
        input  cmd_base,
        output cmd_ready
    );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite blitter: queues draw commands, walks each sprite's texels through a
// synchronous ROM, drops transparent texels, and presents each visible pixel on
// program_x/y/data, which only update on a write_slot edge so the SRAM
// controller never samples a half-updated pixel.
// Optional feature: define BLIT_CLIP_EN to skip texels landing at x>=640 or
// y>=480 (evaluated on the un-wrapped 11-bit sum). Without it, coordinates wrap
// modulo 1024 and are written.
module sprite_blitter #(
    parameter int          SPR_W       = 32,
    parameter int          SPR_H       = 32,
    parameter int          ROM_AW      = 16,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] TRANSPARENT = 16'hF81F
) (
    input  logic              sram_clk,
    input  logic              reset,
    sprite_blitter_if.slave   cmd,
    input  logic              write_slot,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [9:0]        program_x,
    output logic [9:0]        program_y,
    output logic [15:0]       program_data,
    output logic              busy,
    output logic              sprite_done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef struct packed {
        logic [9:0]        x;
        logic [9:0]        y;
        logic [ROM_AW-1:0] base;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_ADV
    } state_t;

    // ---------------- command FIFO ----------------
    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    cmd_t             head;

    state_t           state;

    assign fifo_full     = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty    = (fifo_count == '0);
    // Ready depends only on fullness, so a full FIFO never accepts even when popping.
    assign cmd.cmd_ready = !fifo_full;
    assign fifo_push     = cmd.cmd_valid && !fifo_full;
    assign fifo_pop      = (state == S_IDLE) && !fifo_empty;
    assign head          = fifo_mem[rd_ptr];

    // FIFO storage write.
    // NOTE: the storage array has no reset; the pointers and count alone define
    // which entries are valid, so flushing them is enough.
    always_ff @(posedge sram_clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= '{x: cmd.cmd_x, y: cmd.cmd_y, base: cmd.cmd_base};
        end
    end

    // FIFO pointers and occupancy; reset flushes any queued commands.
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge sram_clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------- sprite walker ----------------
    logic [9:0]       cx;
    logic [9:0]       cy;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [15:0]      texel;
    logic [10:0]      sum_x;
    logic [10:0]      sum_y;
    logic             last_col;
    logic             last_row;
    logic             texel_clipped;

    // Un-wrapped 11-bit coordinates; the low 10 bits are the wrapped pixel position.
    assign sum_x    = 11'(cx) + 11'(col);
    assign sum_y    = 11'(cy) + 11'(row);
    assign last_col = (col == COL_W'(SPR_W - 1));
    assign last_row = (row == ROW_W'(SPR_H - 1));

`ifdef BLIT_CLIP_EN
    assign texel_clipped = (sum_x >= 11'd640) || (sum_y >= 11'd480);
`else
    assign texel_clipped = 1'b0;
`endif

    assign busy = (state != S_IDLE) || !fifo_empty;

    // Main FSM: fetch each texel, skip or emit it on a write slot, then advance.
    always_ff @(posedge sram_clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cx           <= '0;
            cy           <= '0;
            col          <= '0;
            row          <= '0;
            texel        <= '0;
            rom_addr     <= '0;
            program_x    <= '0;
            program_y    <= '0;
            program_data <= '0;
            sprite_done  <= 1'b0;
        end else begin
            sprite_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        cx       <= head.x;
                        cy       <= head.y;
                        col      <= '0;
                        row      <= '0;
                        rom_addr <= head.base;
                        state    <= S_FETCH;
                    end
                end
                // rom_addr already holds the texel address; the ROM samples it here.
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    texel <= rom_data;
                    if ((rom_data == TRANSPARENT) || texel_clipped) begin
                        state <= S_ADV;
                    end else begin
                        state <= S_EMIT;
                    end
                end
                // Hold the previous pixel until the controller's slot edge.
                S_EMIT: begin
                    if (write_slot) begin
                        program_x    <= sum_x[9:0];
                        program_y    <= sum_y[9:0];
                        program_data <= texel;
                        state        <= S_ADV;
                    end
                end
                S_ADV: begin
                    rom_addr <= rom_addr + ROM_AW'(1);
                    if (last_col) begin
                        col <= '0;
                        if (last_row) begin
                            sprite_done <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            row   <= row + ROW_W'(1);
                            state <= S_FETCH;
                        end
                    end else begin
                        col   <= col + COL_W'(1);
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter. A reference model expands each
// accepted command into the list of visible pixels straight from the sprite
// rules; a monitor records every change of program_* and the two are compared.
// Honours BLIT_CLIP_EN the same way the design does.
module tb_sprite_blitter;

    localparam int          SPR_W      = 3;
    localparam int          SPR_H      = 2;
    localparam int          ROM_AW     = 8;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [15:0] TRANSP     = 16'hF81F;

    logic              sram_clk = 1'b0;
    logic              reset;
    logic              write_slot = 1'b0;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [9:0]        program_x;
    logic [9:0]        program_y;
    logic [15:0]       program_data;
    logic              busy;
    logic              sprite_done;

    sprite_blitter_if #(.ROM_AW(ROM_AW)) cmd_bus ();

    sprite_blitter #(
        .SPR_W      (SPR_W),
        .SPR_H      (SPR_H),
        .ROM_AW     (ROM_AW),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TRANSPARENT(TRANSP)
    ) dut (
        .sram_clk    (sram_clk),
        .reset       (reset),
        .cmd         (cmd_bus),
        .write_slot  (write_slot),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .program_x   (program_x),
        .program_y   (program_y),
        .program_data(program_data),
        .busy        (busy),
        .sprite_done (sprite_done)
    );

    always #5 sram_clk = ~sram_clk;

    // Synchronous sprite ROM: data one cycle after the address.
    logic [15:0] rom [256];
    always @(posedge sram_clk) rom_data <= rom[rom_addr];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Observed/expected pixel streams, each entry {x, y, data}.
    logic [35:0] obs_q[$];
    logic [35:0] exp_q[$];
    logic [35:0] last_exp = '0;
    int          done_cnt = 0;
    int          n_sprites = 0;
    int          slot_mode = 0; // 0: never, 1: every other cycle, 2: random

    // write_slot generator.
    initial begin
        forever begin
            @(negedge sram_clk);
            case (slot_mode)
                0:       write_slot = 1'b0;
                1:       write_slot = ~write_slot;
                default: write_slot = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // Monitor: record every program_* change, which must coincide with a slot edge.
    initial begin
        logic [35:0] prev_prog;
        logic [35:0] cur;
        logic        slot_at_edge;
        logic        rst_at_edge;
        prev_prog = '0;
        forever begin
            @(posedge sram_clk);
            slot_at_edge = write_slot;
            rst_at_edge  = reset;
            #1;
            cur = {program_x, program_y, program_data};
            if (rst_at_edge) begin
                prev_prog = cur;
            end else begin
                if (cur !== prev_prog) begin
                    check("update_on_slot_edge", 64'(slot_at_edge), 64'd1);
                    obs_q.push_back(cur);
                    prev_prog = cur;
                end
                if (sprite_done === 1'b1) done_cnt++;
            end
        end
    end

    // Reference model: visible pixels of one sprite in raster order. A pixel equal
    // to the one already on program_* produces no observable change, so it is folded.
    task automatic expect_sprite(input logic [9:0] x, input logic [9:0] y, input logic [ROM_AW-1:0] base);
        for (int r = 0; r < SPR_H; r++) begin
            for (int c = 0; c < SPR_W; c++) begin
                logic [ROM_AW-1:0] a;
                int                sx;
                int                sy;
                bit                skip;
                logic [35:0]       e;
                a    = ROM_AW'((int'(base) + r * SPR_W + c) % 256);
                sx   = int'(x) + c;
                sy   = int'(y) + r;
                skip = (rom[a] == TRANSP);
`ifdef BLIT_CLIP_EN
                if (sx >= 640 || sy >= 480) skip = 1'b1;
`endif
                if (!skip) begin
                    e = {10'(sx % 1024), 10'(sy % 1024), rom[a]};
                    if (e !== last_exp) exp_q.push_back(e);
                    last_exp = e;
                end
            end
        end
    endtask

    // Offer one command starting at a negedge; returns one negedge after acceptance.
    task automatic push_cmd(input logic [9:0] x, input logic [9:0] y, input logic [ROM_AW-1:0] base);
        int waited;
        waited = 0;
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_x     = x;
        cmd_bus.cmd_y     = y;
        cmd_bus.cmd_base  = base;
        while (cmd_bus.cmd_ready !== 1'b1 && waited < 2000) begin
            @(negedge sram_clk);
            waited++;
        end
        check("cmd_accepted", 64'(cmd_bus.cmd_ready), 64'd1);
        if (cmd_bus.cmd_ready === 1'b1) begin
            expect_sprite(x, y, base);
            n_sprites++;
        end
        @(negedge sram_clk);
    endtask

    // Wait for all accepted sprites to finish, then compare the pixel streams.
    task automatic drain(input string tag);
        int waited;
        int n;
        waited = 0;
        cmd_bus.cmd_valid = 1'b0;
        while ((done_cnt < n_sprites || busy !== 1'b0) && waited < 5000) begin
            @(negedge sram_clk);
            waited++;
        end
        check({tag, "_sprite_done_count"}, 64'(done_cnt), 64'(n_sprites));
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_pixel_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_pixel"}, 64'(obs_q[i]), 64'(exp_q[i]));
        end
        obs_q.delete();
        exp_q.delete();
        done_cnt  = 0;
        n_sprites = 0;
    endtask

    task automatic clear_model();
        obs_q.delete();
        exp_q.delete();
        last_exp  = '0;
        done_cnt  = 0;
        n_sprites = 0;
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
        reset             = 1'b1;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_x     = '0;
        cmd_bus.cmd_y     = '0;
        cmd_bus.cmd_base  = '0;
        repeat (3) @(negedge sram_clk);

        // Reset state.
        check("rst_program_x", 64'(program_x), 64'd0);
        check("rst_program_y", 64'(program_y), 64'd0);
        check("rst_program_data", 64'(program_data), 64'd0);
        check("rst_rom_addr", 64'(rom_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sprite_done", 64'(sprite_done), 64'd0);
        check("rst_cmd_ready", 64'(cmd_bus.cmd_ready), 64'd1);
        reset = 1'b0;
        clear_model();
        @(negedge sram_clk);

        // Fully opaque sprite, slot every other cycle.
        for (int i = 0; i < 6; i++) rom[i] = 16'hA000 + 16'(i);
        slot_mode = 1;
        push_cmd(10'd100, 10'd50, 8'd0);
        drain("opaque");

        // Transparent texels are skipped and program_* hold.
        rom[8] = 16'h1111; rom[9] = TRANSP; rom[10] = TRANSP;
        rom[11] = TRANSP;  rom[12] = 16'h2222; rom[13] = TRANSP;
        push_cmd(10'd100, 10'd50, 8'd8);
        drain("transparent");

        // Screen edge: wraps without clipping, skipped with it.
        for (int i = 16; i < 22; i++) rom[i] = 16'hC000 + 16'(i);
        push_cmd(10'd639, 10'd479, 8'd16);
        push_cmd(10'd1022, 10'd1023, 8'd16);
        drain("edge");

        // ROM address wraps past the top of the ROM.
        push_cmd(10'd5, 10'd5, 8'd254);
        drain("rom_wrap");

        // No write slots: FSM parks in EMIT, FIFO fills and back-pressures.
        for (int i = 32; i < 38; i++) rom[i] = 16'h5000 + 16'(i);
        slot_mode = 0;
        @(negedge sram_clk);
        for (int k = 0; k < 5; k++) push_cmd(10'(10 + 20 * k), 10'(10 + 7 * k), 8'd32);
        cmd_bus.cmd_valid = 1'b0;
        check("fifo_full_ready_low", 64'(cmd_bus.cmd_ready), 64'd0);
        repeat (20) @(negedge sram_clk);
        check("stall_no_update", 64'(obs_q.size()), 64'd0);
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_ready_still_low", 64'(cmd_bus.cmd_ready), 64'd0);
        slot_mode = 1;
        drain("stall");

        // Randomized ROM contents, commands, gaps and slot pattern.
        for (int i = 0; i < 256; i++) begin
            rom[i] = ($urandom_range(0, 9) < 3) ? TRANSP : 16'($urandom_range(0, 65535));
            if (rom[i] == TRANSP && $urandom_range(0, 9) >= 3) rom[i] = 16'h0001;
        end
        slot_mode = 2;
        for (int k = 0; k < 16; k++) begin
            push_cmd(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                     8'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) begin
                cmd_bus.cmd_valid = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge sram_clk);
            end
        end
        drain("random");

        // Reset in the middle of a sprite with another one queued.
        for (int i = 64; i < 96; i++) rom[i] = 16'h7000 + 16'(i);
        slot_mode = 1;
        push_cmd(10'd200, 10'd100, 8'd64);
        push_cmd(10'd300, 10'd200, 8'd80);
        cmd_bus.cmd_valid = 1'b0;
        waited = 0;
        while (obs_q.size() == 0 && waited < 200) begin
            @(negedge sram_clk);
            waited++;
        end
        check("rst_mid_first_pixel_seen", 64'(obs_q.size() > 0), 64'd1);
        reset = 1'b1;
        @(negedge sram_clk);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_program", 64'({program_x, program_y, program_data}), 64'd0);
        check("rst_mid_rom_addr", 64'(rom_addr), 64'd0);
        check("rst_mid_sprite_done", 64'(sprite_done), 64'd0);
        check("rst_mid_cmd_ready", 64'(cmd_bus.cmd_ready), 64'd1);
        reset = 1'b0;
        clear_model();
        repeat (20) @(negedge sram_clk);
        check("rst_mid_no_updates", 64'(obs_q.size()), 64'd0);
        check("rst_mid_no_done", 64'(done_cnt), 64'd0);
        check("rst_mid_idle", 64'(busy), 64'd0);

        // A new command after the reset runs normally.
        push_cmd(10'd400, 10'd300, 8'd64);
        drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
